// File: rtl/diff_check_pkg.sv
// Shared types and arithmetic for the differential vector checker:
// FSM states, MISR polynomial, xorshift64 shift amounts, and the fold/step helpers.
package diff_check_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

   localparam int XS_A = 13;
   localparam int XS_B = 7;
   localparam int XS_C = 17;

   // Widest output bus the fold helper accepts. Narrower buses are zero-extended
   // by the caller, which gives exactly the zero-padded last chunk.
   localparam int FOLD_MAX = 4096;

   // XOR of all 32-bit chunks of y.
   function automatic logic [31:0] fold32(input logic [FOLD_MAX-1:0] y);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < FOLD_MAX / 32; i++)
         f = f ^ y[i*32 +: 32];
      return f;
   endfunction

   // One MISR step: shift left with polynomial feedback, then absorb the fold.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] fold);
      return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold;
   endfunction

   // xorshift64 advance: x^=x<<13; x^=x>>7; x^=x<<17.
   function automatic logic [63:0] xs_next(input logic [63:0] x);
      logic [63:0] t;
      t = x ^ (x << XS_A);
      t = t ^ (t >> XS_B);
      t = t ^ (t << XS_C);
      return t;
   endfunction

endpackage

// File: rtl/diff_vector_checker_misr32.sv
// 32-bit multiple-input signature register compacting one OUT_W-bit output stream.
module misr32
   import diff_check_pkg::*;
#(
   parameter int OUT_W = 421
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [OUT_W-1:0] data,
   output logic [31:0]      sig
);

   logic [FOLD_MAX-1:0] ext;
   logic [31:0]         fold;

   // Zero-extend the bus to the helper width and fold it to 32 bits.
   always_comb begin
      ext              = '0;
      ext[OUT_W-1:0]   = data;
      fold             = fold32(ext);
   end

   // Signature register: reset beats clear, clear beats a capture step.
   always_ff @(posedge clk) begin
      if (rst)
         sig <= '0;
      else if (clr)
         sig <= '0;
      else if (en)
         sig <= misr_step(sig, fold);
   end

endmodule

// File: rtl/diff_vector_checker.sv
// Differential checker: drives one stimulus vector into a reference and a
// synthesized design, compares their outputs LAT edges later, counts mismatches,
// records the first failing index and compacts both output streams into MISRs.
module diff_vector_checker
   import diff_check_pkg::*;
#(
   parameter int          IN_W    = 63,
   parameter int          OUT_W   = 421,
   parameter int          NUM_VEC = 21,
   parameter int          LAT     = 1,
   parameter logic [63:0] SEED    = 64'h3600cb9c416dfc89
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         mode,
   input  logic                         vec_valid,
   input  logic [IN_W-1:0]              vec_data,
   output logic                         vec_ready,
   output logic [IN_W-1:0]              dut_in,
   input  logic [OUT_W-1:0]             ref_y,
   input  logic [OUT_W-1:0]             dut_y,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [$clog2(NUM_VEC+1)-1:0] mismatch_cnt,
   output logic [$clog2(NUM_VEC+1)-1:0] first_mis_idx,
   output logic [31:0]                  sig_ref,
   output logic [31:0]                  sig_dut
);

   localparam int CW = $clog2(NUM_VEC + 1);

   // A zero xorshift state would lock up at zero forever.
   localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;

   // WAIT lasts LAT-1 cycles; the counter runs 0..LAT-2.
   localparam int             WCW       = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((LAT > 1) ? LAT - 2 : 0);

   localparam logic [CW-1:0] IDX_LAST = CW'(NUM_VEC - 1);
   localparam logic [CW-1:0] IDX_NONE = CW'(NUM_VEC);

   localparam state_t AFTER_APPLY = (LAT > 1) ? S_WAIT : S_CAPTURE;

   state_t         state;
   logic           mode_q;
   logic [63:0]    xs;
   logic [CW-1:0]  idx;
   logic [WCW-1:0] wcnt;
   logic [IN_W-1:0] xs_stim;
   logic           run_start;
   logic           cap_en;
   logic           hit;

   // Internal stimulus: low IN_W bits of the xorshift word repeated across the bus.
   always_comb begin
      xs_stim = '0;
      for (int i = 0; i < IN_W; i++)
         xs_stim[i] = xs[i % 64];
   end

   assign run_start = start && ((state == S_IDLE) || (state == S_DONE));
   assign cap_en    = (state == S_CAPTURE);
   assign hit       = (ref_y != dut_y);
   assign vec_ready = (state == S_APPLY) && mode_q;
   assign pass      = done && (mismatch_cnt == '0);

   // Run control FSM with stimulus register, mismatch bookkeeping and xorshift state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         mode_q        <= 1'b0;
         dut_in        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         mismatch_cnt  <= '0;
         first_mis_idx <= IDX_NONE;
         xs            <= SEED_EFF;
         idx           <= '0;
         wcnt          <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mode_q        <= mode;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  mismatch_cnt  <= '0;
                  first_mis_idx <= IDX_NONE;
                  idx           <= '0;
                  wcnt          <= '0;
                  state         <= S_APPLY;
               end
            end
            S_APPLY: begin
               if (!mode_q) begin
                  dut_in <= xs_stim;
                  xs     <= xs_next(xs);
                  wcnt   <= '0;
                  state  <= AFTER_APPLY;
               end else if (vec_valid) begin
                  dut_in <= vec_data;
                  wcnt   <= '0;
                  state  <= AFTER_APPLY;
               end
            end
            S_WAIT: begin
               if (wcnt == WAIT_LAST)
                  state <= S_CAPTURE;
               else
                  wcnt <= wcnt + WCW'(1);
            end
            S_CAPTURE: begin
               if (hit) begin
                  mismatch_cnt <= mismatch_cnt + CW'(1);
                  if (mismatch_cnt == '0)
                     first_mis_idx <= idx;
               end
               idx <= idx + CW'(1);
               if (idx == IDX_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_APPLY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   misr32 #(.OUT_W(OUT_W)) u_misr_ref (
      .clk  (clk),
      .rst  (rst),
      .clr  (run_start),
      .en   (cap_en),
      .data (ref_y),
      .sig  (sig_ref)
   );

   misr32 #(.OUT_W(OUT_W)) u_misr_dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (run_start),
      .en   (cap_en),
      .data (dut_y),
      .sig  (sig_dut)
   );

endmodule

// File: doc/diff_vector_checker.md
Name: diff_vector_checker

Overview:
- Synthesizable differential stimulus/response checker for fuzz-simulation flows.
- Drives a parametrised input vector into two versions of a design under test:
  - the reference netlist;
  - the synthesized netlist.
- Samples both outputs after a programmable latency, compares them every vector, and compacts each output stream into a 32-bit signature.
- Replaces per-cycle output dumping with an on-chip pass/fail verdict, a mismatch count and the index of the first mismatch.

Parameters:
- IN_W, 63: width of the stimulus bus applied to both designs.
- OUT_W, 421: width of each design's output bus.
- NUM_VEC, 21: number of vectors per run (≥1).
- LAT, 1: clock edges between applying a vector and sampling outputs (≥1).
- SEED, 64'h3600cb9c416dfc89: initial xorshift64 state. A value of 0 is replaced by 64'h1.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- mode  in  1  stimulus source: 0 = internal xorshift64, 1 = external stream. Sampled with start.
- vec_valid  in  1  external vector valid (used only when mode=1).
- vec_data  in  IN_W  external vector.
- vec_ready  out  1  high in APPLY when mode=1.
- dut_in  out  IN_W  registered stimulus to both designs.
- ref_y  in  OUT_W  reference design output.
- dut_y  in  OUT_W  synthesized design output.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or rst.
- pass  out  1  done && mismatch_cnt==0.
- mismatch_cnt  out  $clog2(NUM_VEC+1)  number of mismatching vectors.
- first_mis_idx  out  $clog2(NUM_VEC+1)  index of the first mismatching vector; equals NUM_VEC if there was none.
- sig_ref  out  32  MISR signature of ref_y.
- sig_dut  out  32  MISR signature of dut_y.

Behaviour:
- Reset values:
  - State IDLE.
  - dut_in=0, vec_ready=0, busy=0, done=0, pass=0, mismatch_cnt=0.
  - first_mis_idx=NUM_VEC, sig_ref=sig_dut=0.
  - xorshift state=SEED (or 1 if SEED is 0), vector index=0.
- Reset precedence: rst wins over start in the same cycle. rst mid-run aborts immediately to reset values.
- States: IDLE, APPLY, WAIT, CAPTURE, DONE.
- IDLE/DONE + start:
  - Clear the counters and signatures, set first_mis_idx=NUM_VEC, latch mode, set busy=1, clear done.
  - Go to APPLY.
- APPLY, mode=0:
  - dut_in <= lower IN_W bits of the xorshift state replicated ceil(IN_W/64) times.
  - Advance the state: x^=x<<13; x^=x>>7; x^=x<<17.
  - Go to WAIT if LAT>1, else CAPTURE.
- APPLY, mode=1:
  - vec_ready=1. Stay in APPLY until vec_valid.
  - On the handshake, dut_in <= vec_data and move on as above. No other transfer is accepted.
- WAIT: count LAT-1 cycles in total, then go to CAPTURE.
- CAPTURE (ref_y and dut_y are sampled at the edge ending this state, exactly LAT edges after dut_in updated):
  - If ref_y != dut_y: mismatch_cnt += 1. If this is the first mismatch, first_mis_idx <= vector index.
  - Update each MISR:
    - fold = XOR of the 32-bit chunks of y, last chunk zero-padded;
    - sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
  - Increment the index. If the index was NUM_VEC-1, go to DONE (busy=0, done=1), else go to APPLY.
- Timing:
  - Mode 0 takes exactly LAT+1 cycles per vector.
  - Counting the edge that samples start as edge 0, done is registered high at edge NUM_VEC*(LAT+1).
- dut_in holds its value between vectors and in DONE.
- Signatures and counters are frozen in DONE and readable until the next start.
- start in DONE begins a new run. The xorshift state continues from where it stopped; it is not reseeded except by rst.

Decomposition:
- Shared package diff_check_pkg holds:
  - the state enum;
  - the MISR polynomial constant 32'h04C11DB7;
  - the xorshift shift constants 13/7/17;
  - a fold function.
- One sub-module, misr32, takes (clk, rst, clr, en, OUT_W-bit data) and produces sig. It is instantiated twice.

Test Plan:
1. Equal outputs:
   - Stimulus: IN_W=8, OUT_W=8, NUM_VEC=4, LAT=2, mode=0; ref_y=dut_y=dut_in (registered externally).
   - Required: done at edge 12, pass=1, mismatch_cnt=0, first_mis_idx=4, sig_ref==sig_dut≠0.
2. Injected fault:
   - Stimulus: as 1, but dut_y bit0 is inverted during vector index 2 only.
   - Required: mismatch_cnt=1, first_mis_idx=2, pass=0, sig_ref≠sig_dut.
3. External stream:
   - Stimulus: mode=1; vectors 8'hA5, 8'h3C, 8'hFF, 8'h00, each with 3-cycle vec_valid gaps.
   - Required: dut_in takes exactly that sequence, one vector per handshake; vec_ready low outside APPLY.
4. Reset mid-run:
   - Stimulus: rst asserted during WAIT of vector 1.
   - Required: all outputs return to reset values next edge. A subsequent start reproduces scenario 1's signatures from SEED.
5. Start ignored while busy:
   - Stimulus: start pulsed while busy.
   - Required: no effect; done still at edge 12.
6. Wide defaults:
   - Stimulus: IN_W=63, OUT_W=421, identical designs, 21 vectors.
   - Required: pass=1, and the signatures match a software model of the fold and MISR.
